router_in_port: RTL

Input-port stage of the mesh router: one instance sits behind each link input (LOCAL, X+, X-, Y+, Y-) and terminates the `DATA / DATA_VALID / FULL` link handshake. It buffers incoming flits in a small FIFO and computes the dimension-ordered (XY) output port from each head flit. It then holds a wormhole request to the switch allocator and crossbar until that packet's tail flit has left. The router top instantiates five of these and feeds their `SW_REQ` / `FLIT_OUT` into its allocator and crossbar.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/noc_fifo.sv | 59 +++++
 rtl/router_in_port.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | noc_pkg : shared mesh-NoC flit encodings, port indices and types |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package noc_pkg;

   localparam int DATA_WIDTH = 32;

   // Flit type lives in the two MSBs of every flit
   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_HEAD   = 2'b01;
   localparam logic [1:0] FLIT_TAIL   = 2'b10;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_XP    = 1;
   localparam int PORT_XN    = 2;
   localparam int PORT_YP    = 3;
   localparam int PORT_YN    = 4;
   localparam int NUM_PORTS  = 5;

   typedef logic [NUM_PORTS-1:0] port_vec_t;

   function automatic logic [1:0] flit_type(input logic [DATA_WIDTH-1:0] flit);
      return flit[DATA_WIDTH-1 -: 2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | noc_fifo : synchronous FIFO with occupancy count, pop-before-push |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module noc_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop_i & ~empty_o;
   // A full FIFO still accepts a write when the same cycle frees a slot
   assign push_ok = push_i & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/router_in_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_in_port : link input buffer, XY route compute, wormhole   |
// | request hold. Optional ERR_OUT with macro ROUTER_IBUF_ERR_EN.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module router_in_port
   import noc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int X_W   = 2,
   parameter int Y_W   = 1,
   parameter int MY_X  = 0,
   parameter int MY_Y  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  DATA_VALID_IN,
   output logic                  FULL_OUT,
   output logic [4:0]            SW_REQ,
   input  logic                  SW_GNT,
   output logic [DATA_WIDTH-1:0] FLIT_OUT,
   output logic                  FLIT_VALID_OUT
`ifdef ROUTER_IBUF_ERR_EN
   ,
   output logic                  ERR_OUT
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   state_e          state_q, state_d;
   port_vec_t       route_q, route_d;
   logic            full_q;
   logic [DATA_WIDTH-1:0] head;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_d;
   logic            empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic            flit_valid;
   logic [1:0]      head_type;
   logic            head_starts;
   logic            head_ends;

   function automatic port_vec_t xy_route(input logic [DATA_WIDTH-1:0] flit);
      logic [X_W-1:0] dx;
      logic [Y_W-1:0] dy;
      port_vec_t      r;
      dx = flit[X_W-1:0];
      dy = flit[X_W+Y_W-1:X_W];
      r  = '0;
      if (dx > X_W'(MY_X))      r[PORT_XP]    = 1'b1;
      else if (dx < X_W'(MY_X)) r[PORT_XN]    = 1'b1;
      else if (dy > Y_W'(MY_Y)) r[PORT_YP]    = 1'b1;
      else if (dy < Y_W'(MY_Y)) r[PORT_YN]    = 1'b1;
      else                      r[PORT_LOCAL] = 1'b1;
      return r;
   endfunction

   noc_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (DATA_IN),
      .rdata_o (head),
      .count_o (count),
      .empty_o (empty)
   );

   assign head_type   = flit_type(head);
   assign head_starts = (head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE);
   assign head_ends   = (head_type == FLIT_TAIL) || (head_type == FLIT_SINGLE);
   assign fifo_full   = (count == CNT_W'(DEPTH));

   always_comb begin
      state_d    = state_q;
      route_d    = route_q;
      pop        = 1'b0;
      flit_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               if (head_starts) begin
                  route_d = xy_route(head);
                  state_d = ACTIVE;
               end else begin
                  // Body/tail with no owning head: discard it
                  pop = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (SW_GNT && !empty) begin
               pop        = 1'b1;
               flit_valid = 1'b1;
               if (head_ends) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign push    = DATA_VALID_IN & (~fifo_full | pop);
   assign count_d = count + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         route_q <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         // Asserted one entry early to cover the flit already on the link
         full_q  <= (count_d >= CNT_W'(DEPTH - 1));
      end
   end

`ifdef ROUTER_IBUF_ERR_EN
   logic err_q;
   logic err_set;

   assign err_set = (DATA_VALID_IN & fifo_full & ~pop)
                  | ((state_q == IDLE) & ~empty & ~head_starts);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign ERR_OUT = err_q;
`endif

   assign FULL_OUT       = full_q;
   assign SW_REQ         = (state_q == ACTIVE) ? route_q : '0;
   assign FLIT_OUT       = empty ? '0 : head;
   assign FLIT_VALID_OUT = flit_valid;

endmodule
`default_nettype wire
